savestate_ctl: RTL and testbench
================================

Name: savestate_ctl

Overview:
- Consumer of the bridge command handler's savestate_start / savestate_load handshakes.
- On a save request, pauses the core and copies WORDS 32-bit words of core state into the bridge-visible savestate buffer RAM.
- On a load request, copies the buffer back into the core.
- Drives the ack/busy/ok/err status the command handler reports to the host.

Parameters:
- WORDS, 256, number of 32-bit state words transferred per operation (1..2^AW).
- AW, 8, address width of the state port and the buffer port.
- TIMEOUT, 1023, max cycles to wait for core_paused or for any single st_ack before aborting with err.

Ports:
- clk  in  1  sole clock; all inputs are synchronous to it.
- reset  in  1  synchronous, active-high reset.
- savestate_start  in  1  save request level from the command handler; acted on at its rising edge.
- savestate_start_ack  out  1  one-cycle acknowledge of a save request.
- savestate_start_busy  out  1  save in progress.
- savestate_start_ok  out  1  last save completed.
- savestate_start_err  out  1  last save aborted.
- savestate_load  in  1  load request level; acted on at its rising edge.
- savestate_load_ack / _busy / _ok / _err  out  1 each  same meaning as the save set, for loads.
- core_pause  out  1  request for the core to halt.
- core_paused  in  1  core has halted.
- st_addr  out  AW  core state word index.
- st_rd  out  1  state read request; held until st_ack.
- st_rd_data  in  32  read data, valid in the st_ack cycle.
- st_wr  out  1  state write request; held until st_ack.
- st_wr_data  out  32  write data.
- st_ack  in  1  completes the current st_rd or st_wr.
- buf_addr  out  AW  buffer RAM word address.
- buf_wr  out  1  buffer write strobe.
- buf_wr_data  out  32  buffer write data.
- buf_rd_data  in  32  buffer read data; sync RAM, valid 1 cycle after buf_addr.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, edge registers and pending flags cleared. Reset mid-operation aborts the transfer immediately; core_pause drops the next cycle; no ok/err is raised.
- Edge detect: each request input is registered; rising edge sets pend_save / pend_load. Edges arriving while busy are latched and served after the current operation finishes.
- IDLE: if pend_save, serve the save; else if pend_load, serve the load. Save wins when both are pending; the load waits and is not dropped.
- Serving an operation:
  - Clear the pending flag.
  - Pulse *_ack for exactly 1 cycle (the cycle after leaving IDLE).
  - In the same cycle: set *_busy, clear that operation's own *_ok and *_err. The other operation's status is untouched.
  - Assert core_pause, go to PAUSE.
- PAUSE: wait for core_paused. Timeout counter reset on entry; reaching TIMEOUT goes to ERR. Word index idx = 0.
- SAVE_RD: st_addr = idx, st_rd = 1 until st_ack. On ack, capture st_rd_data and go to SAVE_WR. Timeout per word, reset on each new request.
- SAVE_WR: one cycle with buf_wr = 1, buf_addr = idx, buf_wr_data = captured word. If idx == WORDS-1, go to OK; else idx += 1 and return to SAVE_RD.
- LOAD_RA: drive buf_addr = idx for 1 cycle (RAM latency), then LOAD_WR.
- LOAD_WR: st_wr_data = buf_rd_data, registered on LOAD_WR entry. st_addr = idx, st_wr = 1 until st_ack. Timeout as above. On ack: if last word go to OK, else idx += 1 and return to LOAD_RA.
- OK: busy = 0, *_ok = 1, core_pause = 0, go to IDLE.
- ERR: busy = 0, *_err = 1, core_pause = 0, st_rd / st_wr deasserted, go to IDLE.
- *_ok and *_err are sticky until the next ack of the same operation. They are never both 1.
- idx is AW bits and never wraps, because the last-word compare terminates the loop.
- Save cycle count per word with 0-wait ack: 3 (RD request, ack cycle, WR).

Test Plan:
- Save, WORDS=4, st_ack 1 cycle after each st_rd, core state {11,22,33,44}, savestate_start rises → ack high exactly 1 cycle; buf writes addr 0..3 with data 11,22,33,44; start_ok=1, busy=0, core_pause=0 after the last write.
- Load with buffer preloaded {A0,A1,A2,A3}, savestate_load rises → st_wr at addr 0..3 with data A0..A3; load_ok=1; start_ok from the prior save still 1.
- savestate_start and savestate_load rise in the same cycle → full save completes first, then load_ack pulses and the load runs; both ok=1 at the end.
- core_paused never asserted, TIMEOUT=15 → start_err=1 within 16–18 cycles of ack; core_pause=0; no buf_wr ever issued.
- st_ack withheld on word 2 of a save → err after TIMEOUT; next save request clears err on ack and completes with ok.
- reset asserted during SAVE_RD of word 1 → the next cycle all outputs are 0 and st_rd is low; a fresh start edge after reset runs normally from addr 0.

Source files
------------

// File: rtl/savestate_ctl.sv
// savestate_ctl: pauses the core and moves WORDS state words between the core state port and the savestate buffer RAM.
module savestate_ctl #(
    parameter int WORDS   = 256,
    parameter int AW      = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          savestate_start,
    output logic          savestate_start_ack,
    output logic          savestate_start_busy,
    output logic          savestate_start_ok,
    output logic          savestate_start_err,
    input  logic          savestate_load,
    output logic          savestate_load_ack,
    output logic          savestate_load_busy,
    output logic          savestate_load_ok,
    output logic          savestate_load_err,
    output logic          core_pause,
    input  logic          core_paused,
    output logic [AW-1:0] st_addr,
    output logic          st_rd,
    input  logic [31:0]   st_rd_data,
    output logic          st_wr,
    output logic [31:0]   st_wr_data,
    input  logic          st_ack,
    output logic [AW-1:0] buf_addr,
    output logic          buf_wr,
    output logic [31:0]   buf_wr_data,
    input  logic [31:0]   buf_rd_data
);
    localparam int TW = $clog2(TIMEOUT + 2);

    typedef enum logic [2:0] {IDLE, PAUSE, SAVE_RD, SAVE_WR, LOAD_RA, LOAD_WR, OK, ERR} state_t;

    state_t        state_q;
    logic          op_q;
    logic          start_in_q, load_in_q;
    logic          pend_save_q, pend_load_q;
    logic [AW-1:0] idx_q;
    logic [TW-1:0] tmo_q;
    logic          sack_q, sbusy_q, sok_q, serr_q;
    logic          lack_q, lbusy_q, lok_q, lerr_q;
    logic          core_pause_q, st_rd_q, st_wr_q, buf_wr_q;
    logic [AW-1:0] st_addr_q, buf_addr_q;
    logic [31:0]   st_wr_data_q, buf_wr_data_q;
    logic          rise_save, rise_load, last, tmo_hit;

    assign rise_save = savestate_start & ~start_in_q;
    assign rise_load = savestate_load & ~load_in_q;
    assign last      = idx_q == AW'(WORDS - 1);
    assign tmo_hit   = tmo_q == TW'(TIMEOUT);

    assign savestate_start_ack  = sack_q;
    assign savestate_start_busy = sbusy_q;
    assign savestate_start_ok   = sok_q;
    assign savestate_start_err  = serr_q;
    assign savestate_load_ack   = lack_q;
    assign savestate_load_busy  = lbusy_q;
    assign savestate_load_ok    = lok_q;
    assign savestate_load_err   = lerr_q;
    assign core_pause           = core_pause_q;
    assign st_addr              = st_addr_q;
    assign st_rd                = st_rd_q;
    assign st_wr                = st_wr_q;
    assign st_wr_data           = st_wr_data_q;
    assign buf_addr             = buf_addr_q;
    assign buf_wr               = buf_wr_q;
    assign buf_wr_data          = buf_wr_data_q;

    // Request edge capture plus the transfer FSM; every output is a register written here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            op_q          <= 1'b0;
            start_in_q    <= 1'b0;
            load_in_q     <= 1'b0;
            pend_save_q   <= 1'b0;
            pend_load_q   <= 1'b0;
            idx_q         <= '0;
            tmo_q         <= '0;
            sack_q        <= 1'b0;
            sbusy_q       <= 1'b0;
            sok_q         <= 1'b0;
            serr_q        <= 1'b0;
            lack_q        <= 1'b0;
            lbusy_q       <= 1'b0;
            lok_q         <= 1'b0;
            lerr_q        <= 1'b0;
            core_pause_q  <= 1'b0;
            st_rd_q       <= 1'b0;
            st_wr_q       <= 1'b0;
            buf_wr_q      <= 1'b0;
            st_addr_q     <= '0;
            buf_addr_q    <= '0;
            st_wr_data_q  <= '0;
            buf_wr_data_q <= '0;
        end else begin
            start_in_q <= savestate_start;
            load_in_q  <= savestate_load;
            sack_q     <= 1'b0;
            lack_q     <= 1'b0;
            buf_wr_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pend_save_q || pend_load_q) begin
                        op_q <= ~pend_save_q;
                        if (pend_save_q) begin
                            pend_save_q <= 1'b0;
                            sack_q      <= 1'b1;
                            sbusy_q     <= 1'b1;
                            sok_q       <= 1'b0;
                            serr_q      <= 1'b0;
                        end else begin
                            pend_load_q <= 1'b0;
                            lack_q      <= 1'b1;
                            lbusy_q     <= 1'b1;
                            lok_q       <= 1'b0;
                            lerr_q      <= 1'b0;
                        end
                        core_pause_q <= 1'b1;
                        idx_q        <= '0;
                        tmo_q        <= '0;
                        state_q      <= PAUSE;
                    end
                end
                PAUSE: begin
                    if (core_paused) begin
                        tmo_q      <= '0;
                        st_addr_q  <= '0;
                        buf_addr_q <= '0;
                        st_rd_q    <= ~op_q;
                        state_q    <= op_q ? LOAD_RA : SAVE_RD;
                    end else if (tmo_hit) begin
                        state_q <= ERR;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                SAVE_RD: begin
                    if (st_ack) begin
                        st_rd_q       <= 1'b0;
                        buf_wr_q      <= 1'b1;
                        buf_addr_q    <= idx_q;
                        buf_wr_data_q <= st_rd_data;
                        state_q       <= SAVE_WR;
                    end else if (tmo_hit) begin
                        st_rd_q <= 1'b0;
                        state_q <= ERR;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                SAVE_WR: begin
                    if (last) begin
                        state_q <= OK;
                    end else begin
                        idx_q     <= idx_q + 1'b1;
                        st_addr_q <= idx_q + 1'b1;
                        st_rd_q   <= 1'b1;
                        tmo_q     <= '0;
                        state_q   <= SAVE_RD;
                    end
                end
                LOAD_RA: begin
                    state_q <= LOAD_WR;
                end
                LOAD_WR: begin
                    // First cycle here is when the sync RAM word for idx is valid; latch it and raise st_wr.
                    if (!st_wr_q) begin
                        st_wr_q      <= 1'b1;
                        st_wr_data_q <= buf_rd_data;
                        st_addr_q    <= idx_q;
                        tmo_q        <= '0;
                    end else if (st_ack) begin
                        st_wr_q <= 1'b0;
                        if (last) begin
                            state_q <= OK;
                        end else begin
                            idx_q      <= idx_q + 1'b1;
                            buf_addr_q <= idx_q + 1'b1;
                            state_q    <= LOAD_RA;
                        end
                    end else if (tmo_hit) begin
                        st_wr_q <= 1'b0;
                        state_q <= ERR;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                OK: begin
                    core_pause_q <= 1'b0;
                    if (op_q) begin
                        lbusy_q <= 1'b0;
                        lok_q   <= 1'b1;
                    end else begin
                        sbusy_q <= 1'b0;
                        sok_q   <= 1'b1;
                    end
                    state_q <= IDLE;
                end
                ERR: begin
                    core_pause_q <= 1'b0;
                    st_rd_q      <= 1'b0;
                    st_wr_q      <= 1'b0;
                    if (op_q) begin
                        lbusy_q <= 1'b0;
                        lerr_q  <= 1'b1;
                    end else begin
                        sbusy_q <= 1'b0;
                        serr_q  <= 1'b1;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            if (rise_save) pend_save_q <= 1'b1;
            if (rise_load) pend_load_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_savestate_ctl.sv
// tb_savestate_ctl: directed bench for savestate_ctl with a core/RAM responder model.
module tb_savestate_ctl;
    localparam int WORDS = 4, AW = 8, TIMEOUT = 15;

    logic          clk = 1'b0, reset = 1'b1;
    logic          savestate_start = 1'b0, savestate_load = 1'b0;
    logic          savestate_start_ack, savestate_start_busy, savestate_start_ok, savestate_start_err;
    logic          savestate_load_ack, savestate_load_busy, savestate_load_ok, savestate_load_err;
    logic          core_pause, core_paused = 1'b0;
    logic [AW-1:0] st_addr, buf_addr;
    logic          st_rd, st_wr, buf_wr, st_ack = 1'b0;
    logic [31:0]   st_rd_data = '0, st_wr_data, buf_wr_data, buf_rd_data = '0;

    logic [31:0]   core_mem [0:255];
    logic [31:0]   buf_mem [0:255];
    logic [AW-1:0] ram_addr = '0;
    logic          auto_pause = 1'b1;
    int            withhold = -1;
    int            wait_cnt = 0;
    logic [AW-1:0] bw_addr [$];
    logic [31:0]   bw_data [$];
    logic [AW-1:0] sw_addr [$];
    logic [31:0]   sw_data [$];
    int            n_cmp = 0, n_fail = 0;
    int            r_s_ack, r_l_ack, r_s_first, r_l_first, r_s_done, r_e_first;
    logic          r_err_ack, r_busy_ack, r_done;

    always #5 clk = ~clk;

    savestate_ctl #(.WORDS(WORDS), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .savestate_start(savestate_start), .savestate_start_ack(savestate_start_ack),
        .savestate_start_busy(savestate_start_busy), .savestate_start_ok(savestate_start_ok),
        .savestate_start_err(savestate_start_err),
        .savestate_load(savestate_load), .savestate_load_ack(savestate_load_ack),
        .savestate_load_busy(savestate_load_busy), .savestate_load_ok(savestate_load_ok),
        .savestate_load_err(savestate_load_err),
        .core_pause(core_pause), .core_paused(core_paused),
        .st_addr(st_addr), .st_rd(st_rd), .st_rd_data(st_rd_data),
        .st_wr(st_wr), .st_wr_data(st_wr_data), .st_ack(st_ack),
        .buf_addr(buf_addr), .buf_wr(buf_wr), .buf_wr_data(buf_wr_data), .buf_rd_data(buf_rd_data)
    );

    // Core and buffer RAM model: pause follows core_pause, st_ack one cycle after a request, 1-cycle RAM read latency.
    initial begin : responder
        forever begin
            @(negedge clk);
            core_paused = auto_pause & core_pause;
            buf_rd_data = buf_mem[ram_addr];
            ram_addr = buf_addr;
            if (buf_wr) begin
                buf_mem[buf_addr] = buf_wr_data;
                bw_addr.push_back(buf_addr);
                bw_data.push_back(buf_wr_data);
            end
            if (st_ack) begin
                st_ack = 1'b0;
                wait_cnt = 0;
            end else if ((st_rd || st_wr) && !(st_rd && int'(st_addr) == withhold)) begin
                if (wait_cnt >= 1) begin
                    st_ack = 1'b1;
                    if (st_rd) begin
                        st_rd_data = core_mem[st_addr];
                    end else begin
                        core_mem[st_addr] = st_wr_data;
                        sw_addr.push_back(st_addr);
                        sw_data.push_back(st_wr_data);
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic clear_logs();
        bw_addr.delete();
        bw_data.delete();
        sw_addr.delete();
        sw_data.delete();
    endtask

    task automatic trig(input logic s, input logic l);
        @(negedge clk);
        savestate_start = s;
        savestate_load = l;
    endtask

    task automatic run_ops();
        int quiet;
        bit act;
        quiet = 0;
        act = 0;
        r_s_ack = 0; r_l_ack = 0; r_s_first = -1; r_l_first = -1; r_s_done = -1; r_e_first = -1;
        r_err_ack = 1'b1; r_busy_ack = 1'b0; r_done = 1'b0;
        for (int i = 0; i < 400 && !r_done; i++) begin
            @(negedge clk);
            if (i == 0) begin
                savestate_start = 1'b0;
                savestate_load = 1'b0;
            end
            if (savestate_start_ack) begin
                if (r_s_first < 0) begin
                    r_s_first = i;
                    r_err_ack = savestate_start_err;
                    r_busy_ack = savestate_start_busy;
                end
                r_s_ack++;
            end
            if (savestate_load_ack) begin
                if (r_l_first < 0) r_l_first = i;
                r_l_ack++;
            end
            if (r_s_ack > 0 && r_s_done < 0 && (savestate_start_ok || savestate_start_err)) r_s_done = i;
            if (r_s_ack > 0 && r_e_first < 0 && savestate_start_err) r_e_first = i;
            if (savestate_start_busy || savestate_load_busy) act = 1;
            quiet = (act && !savestate_start_busy && !savestate_load_busy) ? quiet + 1 : 0;
            r_done = quiet == 4;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({savestate_start_ack, savestate_start_busy, savestate_start_ok, savestate_start_err,
             savestate_load_ack, savestate_load_busy, savestate_load_ok, savestate_load_err,
             core_pause, st_rd, st_wr, buf_wr, st_addr, buf_addr, st_wr_data, buf_wr_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: some output nonzero (core_pause=%b st_rd=%b busy=%b) required all 0",
                     core_pause, st_rd, savestate_start_busy);
        end
        reset = 1'b0;
    endtask

    task automatic test_save();
        logic [31:0] e [0:3];
        e = '{32'h11, 32'h22, 32'h33, 32'h44};
        for (int k = 0; k < 4; k++) core_mem[k] = e[k];
        clear_logs();
        trig(1'b1, 1'b0);
        run_ops();
        n_cmp++; if (r_done !== 1'b1) begin n_fail++; $display("FAIL save_done: got %b required 1", r_done); end
        n_cmp++; if (r_s_ack !== 1) begin n_fail++; $display("FAIL save_ack_count: got %0d required 1", r_s_ack); end
        n_cmp++; if (r_s_first !== 1) begin n_fail++; $display("FAIL save_ack_latency: got %0d required 1", r_s_first); end
        n_cmp++; if (r_busy_ack !== 1'b1) begin n_fail++; $display("FAIL save_busy_at_ack: got %b required 1", r_busy_ack); end
        n_cmp++; if (bw_addr.size() !== 4) begin n_fail++; $display("FAIL save_buf_writes: got %0d required 4", bw_addr.size()); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (k >= bw_data.size() || bw_addr[k] !== AW'(k) || bw_data[k] !== e[k]) begin
                n_fail++;
                $display("FAIL save_word%0d: got addr=%0d data=%h required addr=%0d data=%h", k,
                         k < bw_addr.size() ? bw_addr[k] : '1, k < bw_data.size() ? bw_data[k] : '1, k, e[k]);
            end
        end
        n_cmp++;
        if ({savestate_start_ok, savestate_start_err, savestate_start_busy, core_pause} !== 4'b1000) begin
            n_fail++;
            $display("FAIL save_status: got ok/err/busy/pause=%b required 1000",
                     {savestate_start_ok, savestate_start_err, savestate_start_busy, core_pause});
        end
    endtask

    task automatic test_load();
        logic [31:0] e [0:3];
        e = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        for (int k = 0; k < 4; k++) buf_mem[k] = e[k];
        clear_logs();
        trig(1'b0, 1'b1);
        run_ops();
        n_cmp++; if (r_done !== 1'b1) begin n_fail++; $display("FAIL load_done: got %b required 1", r_done); end
        n_cmp++; if (r_l_ack !== 1 || r_s_ack !== 0) begin n_fail++; $display("FAIL load_acks: got load=%0d save=%0d required 1/0", r_l_ack, r_s_ack); end
        n_cmp++; if (r_l_first !== 1) begin n_fail++; $display("FAIL load_ack_latency: got %0d required 1", r_l_first); end
        n_cmp++; if (sw_addr.size() !== 4 || bw_addr.size() !== 0) begin n_fail++; $display("FAIL load_write_counts: got st=%0d buf=%0d required 4/0", sw_addr.size(), bw_addr.size()); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (k >= sw_data.size() || sw_addr[k] !== AW'(k) || sw_data[k] !== e[k]) begin
                n_fail++;
                $display("FAIL load_word%0d: got addr=%0d data=%h required addr=%0d data=%h", k,
                         k < sw_addr.size() ? sw_addr[k] : '1, k < sw_data.size() ? sw_data[k] : '1, k, e[k]);
            end
        end
        n_cmp++;
        if ({savestate_load_ok, savestate_load_err, savestate_load_busy, core_pause, savestate_start_ok} !== 5'b10001) begin
            n_fail++;
            $display("FAIL load_status: got lok/lerr/lbusy/pause/sok=%b required 10001",
                     {savestate_load_ok, savestate_load_err, savestate_load_busy, core_pause, savestate_start_ok});
        end
    endtask

    task automatic test_both();
        logic [31:0] e [0:3];
        e = '{32'h55, 32'h66, 32'h77, 32'h88};
        for (int k = 0; k < 4; k++) core_mem[k] = e[k];
        clear_logs();
        trig(1'b1, 1'b1);
        run_ops();
        n_cmp++; if (r_done !== 1'b1) begin n_fail++; $display("FAIL both_done: got %b required 1", r_done); end
        n_cmp++; if (r_s_ack !== 1 || r_l_ack !== 1) begin n_fail++; $display("FAIL both_acks: got save=%0d load=%0d required 1/1", r_s_ack, r_l_ack); end
        n_cmp++; if (r_s_first !== 1) begin n_fail++; $display("FAIL both_save_first: got %0d required 1", r_s_first); end
        n_cmp++; if (r_s_done < 0 || r_l_first <= r_s_done) begin n_fail++; $display("FAIL both_order: got load_ack=%0d save_done=%0d required load after save", r_l_first, r_s_done); end
        n_cmp++; if (bw_data.size() !== 4 || sw_data.size() !== 4) begin n_fail++; $display("FAIL both_counts: got buf=%0d st=%0d required 4/4", bw_data.size(), sw_data.size()); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (k >= sw_data.size() || k >= bw_data.size() || bw_data[k] !== e[k] || sw_data[k] !== e[k]) begin
                n_fail++;
                $display("FAIL both_word%0d: got buf=%h st=%h required %h", k,
                         k < bw_data.size() ? bw_data[k] : '1, k < sw_data.size() ? sw_data[k] : '1, e[k]);
            end
        end
        n_cmp++;
        if ({savestate_start_ok, savestate_load_ok, savestate_start_err, savestate_load_err} !== 4'b1100) begin
            n_fail++;
            $display("FAIL both_status: got sok/lok/serr/lerr=%b required 1100",
                     {savestate_start_ok, savestate_load_ok, savestate_start_err, savestate_load_err});
        end
    endtask

    task automatic test_pause_timeout();
        auto_pause = 1'b0;
        clear_logs();
        trig(1'b1, 1'b0);
        run_ops();
        auto_pause = 1'b1;
        n_cmp++; if (r_done !== 1'b1) begin n_fail++; $display("FAIL ptmo_done: got %b required 1", r_done); end
        n_cmp++;
        if (r_e_first < 0 || r_s_first < 0 || r_e_first - r_s_first < 16 || r_e_first - r_s_first > 18) begin
            n_fail++;
            $display("FAIL ptmo_latency: got %0d cycles after ack required 16..18", r_e_first - r_s_first);
        end
        n_cmp++;
        if ({savestate_start_err, savestate_start_ok, savestate_start_busy, core_pause} !== 4'b1000) begin
            n_fail++;
            $display("FAIL ptmo_status: got err/ok/busy/pause=%b required 1000",
                     {savestate_start_err, savestate_start_ok, savestate_start_busy, core_pause});
        end
        n_cmp++; if (bw_addr.size() !== 0) begin n_fail++; $display("FAIL ptmo_no_buf_wr: got %0d writes required 0", bw_addr.size()); end
    endtask

    task automatic test_ack_timeout();
        for (int k = 0; k < 4; k++) core_mem[k] = 32'hC0 + k;
        withhold = 2;
        clear_logs();
        trig(1'b1, 1'b0);
        run_ops();
        withhold = -1;
        n_cmp++; if (r_done !== 1'b1) begin n_fail++; $display("FAIL atmo_done: got %b required 1", r_done); end
        n_cmp++;
        if ({savestate_start_err, savestate_start_ok, st_rd, core_pause} !== 4'b1000) begin
            n_fail++;
            $display("FAIL atmo_status: got err/ok/st_rd/pause=%b required 1000",
                     {savestate_start_err, savestate_start_ok, st_rd, core_pause});
        end
        n_cmp++; if (bw_addr.size() !== 2) begin n_fail++; $display("FAIL atmo_buf_writes: got %0d required 2", bw_addr.size()); end
        clear_logs();
        trig(1'b1, 1'b0);
        run_ops();
        n_cmp++; if (r_err_ack !== 1'b0) begin n_fail++; $display("FAIL atmo_err_cleared_at_ack: got %b required 0", r_err_ack); end
        n_cmp++;
        if ({savestate_start_ok, savestate_start_err} !== 2'b10 || bw_addr.size() !== 4) begin
            n_fail++;
            $display("FAIL atmo_retry: got ok/err=%b writes=%0d required 10 and 4",
                     {savestate_start_ok, savestate_start_err}, bw_addr.size());
        end
    endtask

    task automatic test_reset_mid();
        bit hit;
        hit = 0;
        for (int k = 0; k < 4; k++) core_mem[k] = 32'hD0 + k;
        clear_logs();
        trig(1'b1, 1'b0);
        @(negedge clk);
        savestate_start = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            hit = st_rd && st_addr == AW'(1);
        end
        n_cmp++; if (!hit) begin n_fail++; $display("FAIL rst_reach_word1: got %b required 1", hit); end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({savestate_start_ack, savestate_start_busy, savestate_start_ok, savestate_start_err,
             savestate_load_ack, savestate_load_busy, savestate_load_ok, savestate_load_err,
             core_pause, st_rd, st_wr, buf_wr, st_addr, buf_addr, st_wr_data, buf_wr_data} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got pause=%b st_rd=%b busy=%b addr=%0d required all 0",
                     core_pause, st_rd, savestate_start_busy, st_addr);
        end
        reset = 1'b0;
        @(negedge clk);
        clear_logs();
        trig(1'b1, 1'b0);
        run_ops();
        n_cmp++;
        if (r_done !== 1'b1 || savestate_start_ok !== 1'b1 || bw_addr.size() !== 4) begin
            n_fail++;
            $display("FAIL rst_fresh_save: got done=%b ok=%b writes=%0d required 1/1/4", r_done, savestate_start_ok, bw_addr.size());
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (k >= bw_data.size() || bw_addr[k] !== AW'(k) || bw_data[k] !== 32'hD0 + k) begin
                n_fail++;
                $display("FAIL rst_fresh_word%0d: got addr=%0d data=%h required addr=%0d data=%h", k,
                         k < bw_addr.size() ? bw_addr[k] : '1, k < bw_data.size() ? bw_data[k] : '1, k, 32'hD0 + k);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 256; k++) begin
            core_mem[k] = '0;
            buf_mem[k] = '0;
        end
        test_reset();
        test_save();
        test_load();
        test_both();
        test_pause_timeout();
        test_ack_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
